// File: rtl/mmio_irq_timer_if.sv
// Data-memory bus bundle between the load/store unit and memory-mapped responders.
// The master drives the access; the slave returns combinational load data.
interface mmio_irq_timer_if;
    logic        st_en_i;
    logic [2:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] st_data_i;
    logic [31:0] ld_data_o;

    modport master (output st_en_i, mem_op_i, addr_i, st_data_i, input ld_data_o);
    modport slave  (input st_en_i, mem_op_i, addr_i, st_data_i, output ld_data_o);
endinterface

// File: rtl/mmio_irq_timer.sv
// Memory-mapped prescaled timer with compare/auto-reload, edge-detected external
// interrupt lines and pending/enable registers driving one registered interrupt request.
module mmio_irq_timer #(
    parameter int unsigned N_EXT   = 4,
    parameter logic [3:0]  WIN_SEL = 4'hA
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mmio_irq_timer_if.slave  bus,
    input  logic [N_EXT-1:0] ext_irq_i,
    output logic             irq_o
);
    localparam int unsigned NP = N_EXT + 1;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_COUNT    = 3'd1,
        REG_CMP      = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_PEND = 3'd4,
        REG_IRQ_ID   = 3'd5
    } reg_idx_e;

    logic          sel;
    logic [2:0]    reg_idx;
    logic [3:0]    byte_mask, wr_mask;
    logic [31:0]   lane_bits;
    logic          tick, cmp_hit;

    logic          ctrl_en_q, ctrl_en_d, ctrl_ar_q, ctrl_ar_d;
    logic [7:0]    presc_q, presc_d, pcnt_q, pcnt_d;
    logic [31:0]   count_q, count_d, cmp_q, cmp_d;
    logic [NP-1:0] irq_en_q, irq_en_d, pend_q, pend_d, pend_set, pend_clr;
    logic [N_EXT-1:0] ext_q, ext_d;
    logic          irq_q, irq_d;

    logic [31:0]   reg_word, irq_id, ld_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{bus.addr_i[31:12], bus.addr_i[7:5]};

    assign sel     = (bus.addr_i[11:8] == WIN_SEL);
    assign reg_idx = bus.addr_i[4:2];

    always_comb begin
        byte_mask = 4'b0000;
        unique case (bus.mem_op_i[1:0])
            2'b00:   byte_mask[bus.addr_i[1:0]] = 1'b1;
            2'b01:   byte_mask = bus.addr_i[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    end

    assign wr_mask   = (sel && bus.st_en_i) ? byte_mask : 4'b0000;
    assign lane_bits = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};

    // Lowest enabled pending source wins; the descending loop leaves it as the last assignment.
    always_comb begin
        irq_id = '0;
        for (int j = int'(NP) - 1; j >= 0; j--) begin
            if (pend_q[j] && irq_en_q[j]) irq_id = 32'(j + 1);
        end
    end

    always_comb begin
        unique case (reg_idx)
            REG_CTRL:     reg_word = {16'h0000, presc_q, 6'b000000, ctrl_ar_q, ctrl_en_q};
            REG_COUNT:    reg_word = count_q;
            REG_CMP:      reg_word = cmp_q;
            REG_IRQ_EN:   reg_word = 32'(irq_en_q);
            REG_IRQ_PEND: reg_word = 32'(pend_q);
            REG_IRQ_ID:   reg_word = irq_id;
            default:      reg_word = '0;
        endcase
        byte_sel = 8'(reg_word >> {bus.addr_i[1:0], 3'b000});
        half_sel = 16'(reg_word >> {bus.addr_i[1], 4'b0000});
        unique case (bus.mem_op_i[1:0])
            2'b00:   ld_data = bus.mem_op_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = bus.mem_op_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            2'b10:   ld_data = reg_word;
            default: ld_data = '0;
        endcase
        if (!sel || bus.st_en_i) ld_data = '0;
    end

    assign bus.ld_data_o = ld_data;

    always_comb begin
        // NOTE: every next-state signal starts from a default so no path through the
        // case statements can leave it unassigned and infer a latch.
        ctrl_en_d = ctrl_en_q;
        ctrl_ar_d = ctrl_ar_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        cmp_d     = cmp_q;
        irq_en_d  = irq_en_q;
        pend_clr  = '0;

        tick    = ctrl_en_q && (pcnt_q == presc_q);
        cmp_hit = tick && (count_q == cmp_q);

        if (ctrl_en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        if (tick)      count_d = (cmp_hit && ctrl_ar_q) ? 32'd0 : count_q + 32'd1;

        // Software writes land after the timer update so they override it lane by lane.
        unique case (reg_idx)
            REG_CTRL: begin
                if (wr_mask[0]) begin
                    ctrl_en_d = bus.st_data_i[0];
                    ctrl_ar_d = bus.st_data_i[1];
                end
                if (wr_mask[1]) begin
                    presc_d = bus.st_data_i[15:8];
                    pcnt_d  = 8'd0;
                end
            end
            REG_COUNT:    if (|wr_mask) count_d = (count_q & ~lane_bits) | (bus.st_data_i & lane_bits);
            REG_CMP:      cmp_d = (cmp_q & ~lane_bits) | (bus.st_data_i & lane_bits);
            REG_IRQ_EN:   irq_en_d = (irq_en_q & ~lane_bits[NP-1:0]) | (bus.st_data_i[NP-1:0] & lane_bits[NP-1:0]);
            REG_IRQ_PEND: pend_clr = bus.st_data_i[NP-1:0] & lane_bits[NP-1:0];
            default: ;
        endcase

        pend_set = {ext_irq_i & ~ext_q, cmp_hit};
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        ext_d    = ext_irq_i;
        irq_d    = |(pend_q & irq_en_q);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_q <= 1'b0;
            ctrl_ar_q <= 1'b0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            count_q   <= '0;
            cmp_q     <= '0;
            irq_en_q  <= '0;
            pend_q    <= '0;
            ext_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            ctrl_ar_q <= ctrl_ar_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            irq_en_q  <= irq_en_d;
            pend_q    <= pend_d;
            ext_q     <= ext_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o = irq_q;
endmodule

// File: tb/tb_mmio_irq_timer.sv
// Self-checking bench for mmio_irq_timer: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural register-level model.
module tb_mmio_irq_timer;
    localparam int          N_EXT = 4;
    localparam logic [31:0] BASE  = 32'h0000_0A00;
    localparam logic [2:0]  OP_B  = 3'b000, OP_H = 3'b001, OP_W = 3'b010;
    localparam logic [2:0]  OP_BU = 3'b100, OP_HU = 3'b101;

    typedef struct {
        logic        st_en;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_ld;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N_EXT-1:0] ext_irq_i;
    logic             irq_o;
    logic [N_EXT-1:0] ext_lvl;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_irq_timer_if bus_if ();

    mmio_irq_timer #(.N_EXT(N_EXT), .WIN_SEL(4'hA)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus_if),
        .ext_irq_i (ext_irq_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: architectural register values plus cycles elapsed since the last tick.
    logic             m_en, m_ar, m_irq;
    logic [7:0]       m_presc;
    int               m_phase;
    logic [31:0]      m_count, m_cmp;
    logic [N_EXT:0]   m_ien, m_pend;
    logic [N_EXT-1:0] m_ext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [2:0] idx);
        case (idx)
            3'd0: return {16'h0, m_presc, 6'h0, m_ar, m_en};
            3'd1: return m_count;
            3'd2: return m_cmp;
            3'd3: return 32'(m_ien);
            3'd4: return 32'(m_pend);
            3'd5: begin
                for (int j = 0; j <= N_EXT; j++)
                    if (m_pend[j] && m_ien[j]) return 32'(j + 1);
                return 32'd0;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic st_en, input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] w, v;
        if (st_en || addr[11:8] != 4'hA) return 32'd0;
        w = m_reg(addr[4:2]);
        case (op[1:0])
            2'b00: begin
                v = (w >> (8 * addr[1:0])) & 32'hFF;
                if (!op[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (16 * addr[1])) & 32'hFFFF;
                if (!op[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            2'b10:   v = w;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_step(input logic rst, input logic st_en, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [N_EXT-1:0] ext);
        logic [3:0]     lanes;
        logic [31:0]    keep, nc, w;
        logic           tick, hit, nirq;
        int             np;
        logic [N_EXT:0] setb, clrb;
        if (rst) begin
            m_en = 0; m_ar = 0; m_irq = 0; m_presc = 0; m_phase = 0;
            m_count = 0; m_cmp = 0; m_ien = 0; m_pend = 0; m_ext = 0;
            return;
        end
        lanes = 4'b0000;
        if (st_en && addr[11:8] == 4'hA) begin
            case (op[1:0])
                2'b00:   lanes[addr[1:0]] = 1'b1;
                2'b01:   lanes = addr[1] ? 4'b1100 : 4'b0011;
                2'b10:   lanes = 4'b1111;
                default: lanes = 4'b0000;
            endcase
        end
        keep = 32'd0;
        for (int k = 0; k < 4; k++) if (lanes[k]) keep[8*k +: 8] = 8'hFF;

        nirq = |(m_pend & m_ien);
        tick = m_en && (m_phase == int'(m_presc));
        hit  = tick && (m_count == m_cmp);
        nc   = m_count;
        if (tick) nc = (hit && m_ar) ? 32'd0 : m_count + 32'd1;
        np = m_phase;
        if (m_en) np = tick ? 0 : m_phase + 1;
        setb = {ext & ~m_ext, hit};
        clrb = '0;

        case (addr[4:2])
            3'd0: if (lanes != 0) begin
                w = (m_reg(3'd0) & ~keep) | (data & keep);
                m_en = w[0]; m_ar = w[1]; m_presc = w[15:8];
                if (lanes[1]) np = 0;
            end
            3'd1: if (lanes != 0) nc = (m_count & ~keep) | (data & keep);
            3'd2: m_cmp = (m_cmp & ~keep) | (data & keep);
            3'd3: begin w = (32'(m_ien) & ~keep) | (data & keep); m_ien = w[N_EXT:0]; end
            3'd4: begin w = data & keep; clrb = w[N_EXT:0]; end
            default: ;
        endcase

        m_pend  = (m_pend & ~clrb) | setb;
        m_count = nc;
        m_phase = np;
        m_ext   = ext;
        m_irq   = nirq;
    endtask

    task automatic drive_cycle(input logic st_en, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [N_EXT-1:0] ext,
                               output logic [31:0] ld, output logic irq);
        bus_if.st_en_i   = st_en;
        bus_if.mem_op_i  = op;
        bus_if.addr_i    = addr;
        bus_if.st_data_i = data;
        ext_irq_i        = ext;
        #1;
        ld  = bus_if.ld_data_o;
        irq = irq_o;
        if (!rst_i) begin
            check("ld_vs_model", ld, exp_load(st_en, op, addr));
            check("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
        end
        model_step(rst_i, st_en, op, addr, data, ext);
        @(posedge clk_i);
        #1;
    endtask

    task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] ld;
        logic        irq;
        drive_cycle(1'b1, op, addr, data, ext_lvl, ld, irq);
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] addr, output logic [31:0] ld, output logic irq);
        drive_cycle(1'b0, op, addr, 32'd0, ext_lvl, ld, irq);
    endtask

    task automatic idle();
        logic [31:0] ld;
        logic        irq;
        drive_cycle(1'b0, OP_W, 32'h0, 32'd0, ext_lvl, ld, irq);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        ext_lvl = '0;
        idle();
        idle();
        rst_i = 1'b0;
    endtask

    vec_t        vecs [19];
    logic [31:0] exp_seq [11];
    logic [31:0] ld;
    logic        irq, seen;
    logic        st_en;
    logic [1:0]  size;
    logic [2:0]  op;
    logic [31:0] addr, data;

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b0, OP_W, BASE + 32'(4 * i), 32'h0, 32'h0};
        vecs[8]  = '{1'b1, OP_B,  BASE + 32'h6, 32'hABAB_ABAB, 32'h0};
        vecs[9]  = '{1'b0, OP_B,  BASE + 32'h6, 32'h0, 32'hFFFF_FFAB};
        vecs[10] = '{1'b0, OP_BU, BASE + 32'h6, 32'h0, 32'h0000_00AB};
        vecs[11] = '{1'b0, OP_W,  BASE + 32'h4, 32'h0, 32'h00AB_0000};
        vecs[12] = '{1'b1, OP_H,  BASE + 32'hA, 32'h1234_1234, 32'h0};
        vecs[13] = '{1'b0, OP_W,  BASE + 32'h8, 32'h0, 32'h1234_0000};
        vecs[14] = '{1'b0, OP_HU, BASE + 32'hA, 32'h0, 32'h0000_1234};
        vecs[15] = '{1'b1, OP_W,  32'h0000_0804, 32'hDEAD_BEEF, 32'h0};
        vecs[16] = '{1'b0, OP_W,  32'h0000_0804, 32'h0, 32'h0};
        vecs[17] = '{1'b0, OP_W,  BASE + 32'h4, 32'h0, 32'h00AB_0000};
        vecs[18] = '{1'b0, OP_H,  BASE + 32'h6, 32'h0, 32'h0000_00AB};
        exp_seq = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0, 32'd1};

        bus_if.st_en_i = 0; bus_if.mem_op_i = OP_W; bus_if.addr_i = 0; bus_if.st_data_i = 0;
        ext_irq_i = '0;
        model_step(1'b1, 1'b0, OP_W, 32'h0, 32'h0, '0);

        // Directed vector table
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive_cycle(vecs[i].st_en, vecs[i].op, vecs[i].addr, vecs[i].data, '0, ld, irq);
            check($sformatf("vec%0d_ld", i), ld, vecs[i].exp_ld);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'd0);
        end

        // Timer: CMP=3, PRESC=1, auto-reload, timer interrupt enabled
        do_reset();
        store(OP_W, BASE + 32'h8,  32'd3);
        store(OP_W, BASE + 32'h0,  32'h0000_0102);
        store(OP_W, BASE + 32'hC,  32'h1);
        store(OP_W, BASE + 32'h0,  32'h0000_0103);
        for (int k = 0; k <= 10; k++) begin
            load(OP_W, BASE + 32'h4, ld, irq);
            check($sformatf("timer_count_%0d", k), ld, exp_seq[k]);
            check($sformatf("timer_irq_%0d", k), {31'b0, irq}, (k >= 9) ? 32'd1 : 32'd0);
        end
        load(OP_W, BASE + 32'h14, ld, irq);
        check("timer_irq_id", ld, 32'd1);

        // External lines
        do_reset();
        store(OP_W, BASE + 32'hC, 32'b110);
        ext_lvl = 4'b0010; idle();
        ext_lvl = 4'b0000; idle();
        ext_lvl = 4'b0001; idle();
        load(OP_W, BASE + 32'h14, ld, irq);
        check("ext_id_2", ld, 32'd2);
        check("ext_irq_high", {31'b0, irq}, 32'd1);
        store(OP_W, BASE + 32'h10, 32'b010);
        load(OP_W, BASE + 32'h14, ld, irq);
        check("ext_id_3", ld, 32'd3);
        store(OP_W, BASE + 32'h10, 32'b100);
        load(OP_W, BASE + 32'h14, ld, irq);
        check("ext_irq_still_high", {31'b0, irq}, 32'd1);
        check("ext_id_none", ld, 32'd0);
        load(OP_W, BASE + 32'h10, ld, irq);
        check("ext_irq_fell", {31'b0, irq}, 32'd0);
        check("ext_level_once", ld, 32'd0);

        // Set event beats a same-cycle W1C
        do_reset();
        ext_lvl = 4'b0001; idle();
        ext_lvl = 4'b0000; idle();
        ext_lvl = 4'b0001;
        store(OP_W, BASE + 32'h10, 32'h2);
        load(OP_W, BASE + 32'h10, ld, irq);
        check("w1c_vs_set", ld, 32'h2);
        store(OP_W, BASE + 32'h10, 32'h2);
        load(OP_W, BASE + 32'h10, ld, irq);
        check("w1c_clears", ld, 32'h0);

        // COUNT write collides with a tick
        do_reset();
        store(OP_W, BASE + 32'h0, 32'h1);
        idle();
        idle();
        store(OP_W, BASE + 32'h4, 32'h10);
        load(OP_W, BASE + 32'h4, ld, irq);
        check("count_write_wins", ld, 32'h10);
        load(OP_W, BASE + 32'h4, ld, irq);
        check("count_after_write", ld, 32'h11);

        // Wrap at all-ones with CMP=0: no pending bit
        do_reset();
        store(OP_W, BASE + 32'h4, 32'hFFFF_FFFF);
        store(OP_W, BASE + 32'h0, 32'h0000_0301);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            load(OP_W, BASE + 32'h4, ld, irq);
            if (ld != 32'hFFFF_FFFF) seen = 1'b1;
        end
        check("wrap_tick_seen", {31'b0, seen}, 32'd1);
        check("wrap_count", ld, 32'h0);
        load(OP_W, BASE + 32'h10, ld, irq);
        check("wrap_no_pend", ld, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N_EXT; b++)
                if ($urandom_range(0, 3) == 0) ext_lvl[b] = ~ext_lvl[b];
            st_en = 1'($urandom_range(0, 1));
            size  = st_en ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
            op    = {1'($urandom_range(0, 1)), size};
            addr  = $urandom;
            addr[11:8] = ($urandom_range(0, 7) == 0) ? 4'h8 : 4'hA;
            case ($urandom_range(0, 3))
                0:       data = $urandom;
                1:       data = {4{8'($urandom_range(0, 3))}};
                2:       data = $urandom & 32'h0000_0303;
                default: data = {4{8'($urandom_range(0, 255))}};
            endcase
            drive_cycle(st_en, op, addr, data, ext_lvl, ld, irq);
        end
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
